// File: rtl/lsu_dbus_if_pkg.sv
// rtl/lsu_dbus_if_pkg.sv - shared encodings and helpers for the load/store bus interface
package lsu_dbus_if_pkg;

  // Load size codes as delivered by the decoder; 2'b11 falls back to word
  typedef enum logic [1:0] {
    TRIM_WORD = 2'b00,
    TRIM_HALF = 2'b01,
    TRIM_BYTE = 2'b10
  } lsu_trim_e;

  // Store size masks before lane shifting
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  // Access width of the pending request; a store mask takes priority over the load trim
  function automatic lsu_trim_e access_size(input logic [3:0] wmask, input logic [1:0] trim);
    if (wmask != 4'b0000) begin
      if (wmask[3] | wmask[2]) return TRIM_WORD;
      else if (wmask[1])       return TRIM_HALF;
      else                     return TRIM_BYTE;
    end
    case (trim)
      2'b01:   return TRIM_HALF;
      2'b10:   return TRIM_BYTE;
      default: return TRIM_WORD;
    endcase
  endfunction

  // Unshifted byte-enable pattern for an access width
  function automatic logic [3:0] size_mask(input lsu_trim_e size);
    case (size)
      TRIM_HALF: return BE_H;
      TRIM_BYTE: return BE_B;
      default:   return BE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dbus_if_load_align.sv
// rtl/lsu_dbus_if_load_align.sv - lane shift, trim and sign/zero extension of load data
module lsu_load_align
  import lsu_dbus_if_pkg::*;
(
  input  logic [1:0]  off,
  input  lsu_trim_e   trim,
  input  logic        sext,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  // Select the addressed bytes and extend them to a full word
  always_comb begin
    result = sh;
    case (trim)
      TRIM_BYTE: result = {{24{sext & sh[7]}}, sh[7:0]};
      TRIM_HALF: result = {{16{sext & sh[15]}}, sh[15:0]};
      default:   result = sh;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_if.sv
// rtl/lsu_dbus_if.sv - MEM-stage load/store unit driving a req/ack data bus
module lsu_dbus_if
  import lsu_dbus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic [3:0]  mem_write_i,
  input  logic [1:0]  mem_trim_i,
  input  logic        mem_sign_extend_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [15:0] tmo_cnt_q;
  logic [1:0]  off_q;
  lsu_trim_e   trim_q;
  logic        sext_q;

  logic        pending;
  logic        is_write;
  lsu_trim_e   size;
  logic        misaligned;
  logic        launch;
  logic        ack_hit;
  logic        timeout_hit;
  logic [3:0]  lane_be;
  logic [31:0] load_result;

  assign pending  = mem_read_i | (|mem_write_i);
  assign is_write = |mem_write_i;
  assign size     = access_size(mem_write_i, mem_trim_i);

  assign misaligned = ((size == TRIM_HALF) && addr_i[0]) ||
                      ((size == TRIM_WORD) && (addr_i[1:0] != 2'b00));

  // Stores use the decoder mask directly; loads enable the lanes they will read
  assign lane_be = is_write ? (mem_write_i << addr_i[1:0]) : (size_mask(size) << addr_i[1:0]);

  assign launch      = (state_q == LSU_IDLE) && pending && !misaligned;
  assign ack_hit     = (state_q == LSU_REQ) && dbus_ack_i;
  assign timeout_hit = (state_q == LSU_REQ) && !dbus_ack_i && (tmo_cnt_q == TMO_LAST);

  lsu_load_align u_load_align (
    .off    (off_q),
    .trim   (trim_q),
    .sext   (sext_q),
    .rdata  (dbus_rdata_i),
    .result (load_result)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  // Next state and the combinational handshake outputs
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    misaligned_o = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (pending) begin
          stall_o = 1'b1;
          if (misaligned) begin
            misaligned_o = 1'b1;
            state_d      = LSU_DONE;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        stall_o = 1'b1;
        if (dbus_ack_i || timeout_hit) state_d = LSU_DONE;
      end
      LSU_DONE: begin
        done_o  = 1'b1;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Registered bus outputs plus the load controls needed when the ack arrives
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      off_q        <= '0;
      trim_q       <= TRIM_WORD;
      sext_q       <= 1'b0;
    end else if (launch) begin
      dbus_req_o   <= 1'b1;
      dbus_we_o    <= is_write;
      dbus_addr_o  <= {addr_i[31:2], 2'b00};
      dbus_be_o    <= lane_be;
      dbus_wdata_o <= wdata_i << {addr_i[1:0], 3'b000};
      off_q        <= addr_i[1:0];
      trim_q       <= size;
      sext_q       <= mem_sign_extend_i;
    end else if (ack_hit || timeout_hit) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
    end
  end

  // Count REQ cycles spent waiting; cleared whenever the bus is not being waited on
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                             tmo_cnt_q <= '0;
    else if ((state_q == LSU_REQ) && (state_d == LSU_REQ)) tmo_cnt_q <= tmo_cnt_q + 16'd1;
    else                                                   tmo_cnt_q <= '0;
  end

  // Write-back data: load result on ack, zero for stores, timeouts and dropped accesses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                          rdata_o <= '0;
    else if (ack_hit)                                   rdata_o <= dbus_we_o ? 32'd0 : load_result;
    else if (timeout_hit)                               rdata_o <= '0;
    else if ((state_q == LSU_IDLE) && pending && misaligned) rdata_o <= '0;
  end

  // Timeout pulse lines up with the DONE cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bus_err_o <= 1'b0;
    else       bus_err_o <= timeout_hit;
  end

endmodule

// File: tb/tb_lsu_dbus_if.sv
// tb/tb_lsu_dbus_if.sv - self-checking bench for lsu_dbus_if
module tb_lsu_dbus_if;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read_i;
  logic [3:0]  mem_write_i;
  logic [1:0]  mem_trim_i;
  logic        mem_sign_extend_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  lsu_dbus_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .mem_read_i        (mem_read_i),
    .mem_write_i       (mem_write_i),
    .mem_trim_i        (mem_trim_i),
    .mem_sign_extend_i (mem_sign_extend_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .stall_o           (stall_o),
    .done_o            (done_o),
    .rdata_o           (rdata_o),
    .misaligned_o      (misaligned_o),
    .bus_err_o         (bus_err_o),
    .dbus_req_o        (dbus_req_o),
    .dbus_we_o         (dbus_we_o),
    .dbus_addr_o       (dbus_addr_o),
    .dbus_be_o         (dbus_be_o),
    .dbus_wdata_o      (dbus_wdata_o),
    .dbus_ack_i        (dbus_ack_i),
    .dbus_rdata_i      (dbus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read_i        = 1'b0;
    mem_write_i       = 4'b0000;
    mem_trim_i        = 2'b00;
    mem_sign_extend_i = 1'b0;
    addr_i            = '0;
    wdata_i           = '0;
  endtask

  // One access: the reference works in byte counts and plain arithmetic, then follows the
  // access cycle by cycle. ack_at is the REQ-cycle index carrying the ack; >= TMO means none.
  task automatic run_txn(input bit rd, input logic [3:0] wm, input logic [1:0] trim, input bit sx,
                         input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                         input logic [31:0] rdat);
    int          size, off, req_cycles, stalls;
    bit          is_wr, mis, to;
    logic [31:0] v, m, exp_r, exp_wdata;
    logic [3:0]  exp_be;
    is_wr = (wm != 4'b0000);
    size  = is_wr ? $countones(wm) : (trim == 2'd1) ? 2 : (trim == 2'd2) ? 1 : 4;
    off   = int'(addr[1:0]);
    mis   = (addr % size) != 0;
    to    = (ack_at >= TMO);
    req_cycles = to ? TMO : ack_at + 1;
    v = rdat >> (8 * off);
    m = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = v & m;
    if (sx && size < 4 && v[8 * size - 1]) v = v | ~m;
    exp_r     = (is_wr || to) ? 32'd0 : v;
    exp_be    = 4'((1 << size) - 1);
    exp_be    = exp_be << off;
    exp_wdata = wd << (8 * off);

    mem_read_i = rd; mem_write_i = wm; mem_trim_i = trim; mem_sign_extend_i = sx;
    addr_i = addr; wdata_i = wd;
    #1;
    stalls = int'(stall_o);
    check("idle_misaligned", {31'd0, misaligned_o}, {31'd0, mis});
    check("idle_req", {31'd0, dbus_req_o}, 32'd0);
    if (mis) begin
      next_cycle();
      check("mis_done", {31'd0, done_o}, 32'd1);
      check("mis_pulse_end", {31'd0, misaligned_o}, 32'd0);
      check("mis_no_req", {31'd0, dbus_req_o}, 32'd0);
      stalls += int'(stall_o);
      clear_inputs();
      check("mis_stall_cycles", stalls, 32'd1);
      next_cycle();
      check("mis_done_once", {31'd0, done_o}, 32'd0);
      return;
    end
    next_cycle();
    for (int k = 0; k < req_cycles; k++) begin
      stalls += int'(stall_o);
      check("req_high", {31'd0, dbus_req_o}, 32'd1);
      check("req_no_done", {31'd0, done_o}, 32'd0);
      if (k == 0) begin
        check("bus_we", {31'd0, dbus_we_o}, {31'd0, is_wr});
        check("bus_addr", dbus_addr_o, {addr[31:2], 2'b00});
        if (is_wr) begin
          check("bus_be", {28'd0, dbus_be_o}, {28'd0, exp_be});
          check("bus_wdata", dbus_wdata_o, exp_wdata);
        end
      end
      if (!to && k == ack_at) begin
        dbus_ack_i = 1'b1; dbus_rdata_i = rdat;
      end
      next_cycle();
      dbus_ack_i = 1'b0; dbus_rdata_i = $urandom;
    end
    stalls += int'(stall_o);
    check("done_pulse", {31'd0, done_o}, 32'd1);
    check("done_req_low", {31'd0, dbus_req_o}, 32'd0);
    check("bus_err", {31'd0, bus_err_o}, {31'd0, to});
    check("rdata", rdata_o, exp_r);
    check("stall_cycles", stalls, 1 + req_cycles);
    clear_inputs();
    next_cycle();
    check("done_once", {31'd0, done_o}, 32'd0);
    check("bus_err_once", {31'd0, bus_err_o}, 32'd0);
    check("rdata_held", rdata_o, exp_r);
  endtask

  initial begin
    logic [3:0]  wm;
    logic [1:0]  trim;
    logic [31:0] addr;
    bit          st;
    int          sz;

    clear_inputs();
    dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    rst_i = 1'b1;
    #12;
    check("rst_req", {31'd0, dbus_req_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_be", {28'd0, dbus_be_o}, 32'd0);
    check("rst_err", {31'd0, bus_err_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    next_cycle();

    // LB, sign-extended from the top lane
    run_txn(1'b1, 4'b0000, 2'd2, 1'b1, 32'h0000_0103, 32'd0, 0, 32'h8000_0000);
    // SH into the upper half
    run_txn(1'b0, 4'b0011, 2'd0, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 0, 32'd0);
    // Misaligned LW
    run_txn(1'b1, 4'b0000, 2'd0, 1'b0, 32'h0000_0005, 32'd0, 0, 32'd0);
    // LHU with a late ack
    run_txn(1'b1, 4'b0000, 2'd1, 1'b0, 32'h0000_0002, 32'd0, 2, 32'hF00D_1234);
    // No ack at all: timeout
    run_txn(1'b1, 4'b0000, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 99, 32'd0);
    // Read and write together: the store wins
    run_txn(1'b1, 4'b1111, 2'd0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h1234_5678);
    // Misaligned SH
    run_txn(1'b0, 4'b0011, 2'd0, 1'b0, 32'h0000_0033, 32'h0000_1111, 0, 32'd0);

    // Ack while idle is ignored
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
    next_cycle();
    dbus_ack_i = 1'b0;
    check("idle_ack_done", {31'd0, done_o}, 32'd0);
    check("idle_ack_req", {31'd0, dbus_req_o}, 32'd0);

    // Reset while waiting in REQ
    mem_read_i = 1'b1; addr_i = 32'h0000_0040;
    next_cycle();
    check("pre_rst_req", {31'd0, dbus_req_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("async_req_drop", {31'd0, dbus_req_o}, 32'd0);
    clear_inputs();
    next_cycle();
    rst_i = 1'b0;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h5555_AAAA;
    next_cycle();
    dbus_ack_i = 1'b0;
    check("late_ack_done", {31'd0, done_o}, 32'd0);
    check("late_ack_req", {31'd0, dbus_req_o}, 32'd0);
    check("late_ack_stall", {31'd0, stall_o}, 32'd0);
    check("late_ack_rdata", rdata_o, 32'd0);
    next_cycle();
    check("post_rst_done", {31'd0, done_o}, 32'd0);

    // Randomized mix of loads, stores, misalignment and timeouts
    for (int i = 0; i < 40; i++) begin
      st   = bit'($urandom_range(0, 1));
      trim = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       wm = 4'b0001;
        1:       wm = 4'b0011;
        default: wm = 4'b1111;
      endcase
      if (!st) wm = 4'b0000;
      sz   = st ? $countones(wm) : (trim == 2'd1) ? 2 : (trim == 2'd2) ? 1 : 4;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
      run_txn(st ? bit'($urandom_range(0, 1)) : 1'b1, wm, trim, bit'($urandom_range(0, 1)),
              addr, $urandom, $urandom_range(0, 5), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
